prbs31_burst_ctrl: RTL and testbench

Burst sequencer for the PRBS31 generator (x^31 + x^28 + 1, Fibonacci, serial output = state bit 30). It loads a seed, enables the generator for a programmed number of bits per burst, inserts idle gaps, and repeats for a programmed burst count or continuously until aborted. It sits between the host/test-mode registers and the generator, and it qualifies the serial stream with a valid strobe for downstream pins or a checker.

---
 rtl/prbs31_burst_ctrl.sv | 172 +++++++++++++++++
 tb/tb_prbs31_burst_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_burst_ctrl.sv
// prbs31_burst_ctrl: seeds, gates and qualifies an external PRBS31 generator.
// Optional one-shot error injection is enabled by defining PRBS_ERR_INJ_EN.
module prbs31_burst_ctrl #(
    parameter int LEN_W = 16,
    parameter int GAP_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [30:0]      seed,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_len,
    input  logic [CNT_W-1:0] num_bursts,
`ifdef PRBS_ERR_INJ_EN
    input  logic             err_inj,
    input  logic [LEN_W-1:0] err_pos,
`endif
    output logic             gen_load,
    output logic [30:0]      gen_seed,
    output logic             gen_en,
    input  logic             gen_bit,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burst_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] idx_next;
    logic             last_bit;
    logic             last_burst;
    logic             gap_end;

    assign idx_next   = burst_idx + CNT_W'(1);
    assign last_bit   = (bit_cnt == len_q - LEN_W'(1));
    assign last_burst = (nb_q != '0) && (idx_next == nb_q);
    assign gap_end    = (gap_cnt == gap_q - GAP_W'(1));

    // Burst sequencer FSM with registered outputs; rst_n is an active-high sync reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            bit_cnt   <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            nb_q      <= '0;
            gen_load  <= 1'b0;
            gen_seed  <= 31'd1;
            gen_en    <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            burst_idx <= '0;
        end else if (state != S_IDLE && abort) begin
            state     <= S_IDLE;
            gen_load  <= 1'b0;
            gen_en    <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && burst_len != '0) begin
                        state     <= S_LOAD;
                        len_q     <= burst_len;
                        gap_q     <= gap_len;
                        nb_q      <= num_bursts;
                        gen_seed  <= (seed == '0) ? 31'd1 : seed;
                        burst_idx <= '0;
                        gen_load  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state     <= S_RUN;
                    gen_load  <= 1'b0;
                    gen_en    <= 1'b1;
                    bit_valid <= 1'b1;
                    bit_cnt   <= '0;
                end
                S_RUN: begin
                    if (last_bit) begin
                        burst_idx <= idx_next;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        if (last_burst) begin
                            state     <= S_DONE;
                            gen_en    <= 1'b0;
                            bit_valid <= 1'b0;
                            done      <= 1'b1;
                        end else if (gap_q != '0) begin
                            state     <= S_GAP;
                            gen_en    <= 1'b0;
                            bit_valid <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + LEN_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state     <= S_RUN;
                        gen_en    <= 1'b1;
                        bit_valid <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PRBS_ERR_INJ_EN
    logic             armed;
    logic             inj_act;
    logic [LEN_W-1:0] inj_pos;
    logic             burst_end;
    logic             burst_start;

    assign burst_end   = (state == S_RUN) && last_bit;
    assign burst_start = !abort &&
                         ((state == S_LOAD) ||
                          (state == S_GAP && gap_end) ||
                          (burst_end && !last_burst && gap_q == '0));

    // Arm on err_inj; the arm binds to the next burst start and dies at its end
    always_ff @(posedge clk) begin
        if (rst_n || (abort && state != S_IDLE)) begin
            armed   <= 1'b0;
            inj_act <= 1'b0;
            inj_pos <= '0;
        end else if (burst_start) begin
            inj_act <= armed;
            inj_pos <= err_pos;
            armed   <= err_inj;
        end else begin
            if (burst_end) inj_act <= 1'b0;
            if (err_inj)   armed   <= 1'b1;
        end
    end

    assign bit_out = gen_bit ^ (inj_act && bit_valid && bit_cnt == inj_pos);
`else
    assign bit_out = gen_bit;
`endif

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// tb_prbs31_burst_ctrl: table vectors, corner sequences and random bursts
// checked against a stream/trace model built from the burst rules.
module tb_prbs31_burst_ctrl;

    localparam int LEN_W = 16;
    localparam int GAP_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [30:0]      seed;
    logic [LEN_W-1:0] burst_len;
    logic [GAP_W-1:0] gap_len;
    logic [CNT_W-1:0] num_bursts;
    logic             gen_load;
    logic [30:0]      gen_seed;
    logic             gen_en;
    logic             gen_bit;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] burst_idx;
`ifdef PRBS_ERR_INJ_EN
    logic             err_inj;
    logic [LEN_W-1:0] err_pos;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    prbs31_burst_ctrl #(
        .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .burst_len(burst_len), .gap_len(gap_len),
        .num_bursts(num_bursts),
`ifdef PRBS_ERR_INJ_EN
        .err_inj(err_inj), .err_pos(err_pos),
`endif
        .gen_load(gen_load), .gen_seed(gen_seed), .gen_en(gen_en),
        .gen_bit(gen_bit), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .done(done), .burst_idx(burst_idx)
    );

    always #5 clk = ~clk;

    // Behavioural PRBS31 generator driven by the DUT strobes
    logic [30:0] g = 31'd0;
    always @(posedge clk) begin
        if (gen_load)    g <= gen_seed;
        else if (gen_en) g <= {g[29:0], g[30] ^ g[27]};
    end
    assign gen_bit = g[30];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output stream: out[i] = seed[30-i] for i<31, then out[i]=out[i-31]^out[i-28]
    bit ref_bits[$];
    task automatic gen_ref(input logic [30:0] s, input int n);
        logic [30:0] s1;
        s1 = (s == '0) ? 31'd1 : s;
        ref_bits.delete();
        for (int i = 0; i < 31; i++) ref_bits.push_back(s1[30-i]);
        for (int i = 31; i < n; i++)
            ref_bits.push_back(ref_bits[i-31] ^ ref_bits[i-28]);
    endtask

    // Per-cycle expectation {valid, bit, done, busy, gen_load} from the cycle after start
    logic [4:0] exp_q[$];
    task automatic build_trace(input logic [30:0] s, input int len,
                               input int gap, input int nb, input int inj);
        int  k;
        logic x;
        k = 0;
        gen_ref(s, len * nb + 31);
        exp_q.delete();
        exp_q.push_back(5'b00011);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < len; i++) begin
                x = ref_bits[k];
                if (b == 0 && i == inj) x = ~x;
                exp_q.push_back({1'b1, x, 3'b010});
                k++;
            end
            if (b < nb - 1)
                for (int i = 0; i < gap; i++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00110);
        exp_q.push_back(5'b00000);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed = $urandom;
        burst_len = LEN_W'($urandom);
        gap_len = GAP_W'($urandom);
        num_bursts = CNT_W'($urandom);
    endtask

    task automatic run_trace(input string tag, input logic [30:0] s,
                             input int len, input int gap, input int nb,
                             input int inj);
        logic [4:0] act;
        build_trace(s, len, gap, nb, inj);
        seed = s;
        burst_len = LEN_W'(len);
        gap_len = GAP_W'(gap);
        num_bursts = CNT_W'(nb);
        pulse_start();
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            act = {bit_valid, bit_valid & bit_out, done, busy, gen_load};
            chk($sformatf("%s t%0d", tag, t), act, exp_q[t]);
        end
        chk({tag, " idx"}, burst_idx, nb);
    endtask

    typedef struct {
        logic [30:0] seed;
        int          len;
        int          gap;
        int          nb;
        int          nvalid;
        logic [31:0] bits;
        int          done_t;
        int          idx;
        logic [30:0] gseed;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int n, input vec_t v);
        int          nv;
        int          dt;
        logic [31:0] got;
        nv = 0;
        dt = -1;
        got = '0;
        seed = v.seed;
        burst_len = LEN_W'(v.len);
        gap_len = GAP_W'(v.gap);
        num_bursts = CNT_W'(v.nb);
        pulse_start();
        @(negedge clk);
        chk($sformatf("vec%0d gen_load", n), gen_load, 1);
        chk($sformatf("vec%0d gen_seed", n), gen_seed, v.gseed);
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (bit_valid) begin
                if (nv < 32) got[nv] = bit_out;
                nv++;
            end
            if (done) begin
                dt = t;
                break;
            end
        end
        chk($sformatf("vec%0d done_t", n), dt, v.done_t);
        chk($sformatf("vec%0d nvalid", n), nv, v.nvalid);
        chk($sformatf("vec%0d bits", n), got, v.bits);
        chk($sformatf("vec%0d idx", n), burst_idx, v.idx);
        @(negedge clk);
        chk($sformatf("vec%0d busy_after", n), busy, 0);
    endtask

    initial begin
        int   nv;
        int   seen_done;
        logic [30:0] s;
        logic [31:0] bad_bits;

        vecs[0] = '{31'h4000_0000, 8, 0, 1, 8, 32'h1, 9, 1, 31'h4000_0000};
        vecs[1] = '{31'h0, 31, 5, 1, 31, 32'h4000_0000, 32, 1, 31'd1};
        vecs[2] = '{31'h7FFF_FFFF, 4, 3, 3, 12, 32'hFFF, 19, 3, 31'h7FFF_FFFF};
        vecs[3] = '{31'h5555_5555, 5, 0, 2, 10, 32'h155, 11, 2, 31'h5555_5555};
        vecs[4] = '{31'h0000_0001, 1, 0, 1, 1, 32'h0, 2, 1, 31'h1};

        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seed = '0;
        burst_len = '0;
        gap_len = '0;
        num_bursts = '0;
`ifdef PRBS_ERR_INJ_EN
        err_inj = 1'b0;
        err_pos = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst outputs",
            {gen_load, gen_en, bit_valid, busy, done, burst_idx}, 0);
        chk("rst gen_seed", gen_seed, 31'd1);
        rst_n = 1'b0;
        @(negedge clk);

        // start with zero length is ignored
        seed = 31'h123;
        burst_len = '0;
        num_bursts = 8'd1;
        pulse_start();
        @(negedge clk);
        chk("len0 busy", {busy, gen_load}, 0);
        @(negedge clk);
        chk("len0 busy2", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // continuous run aborted on the 100th valid bit
        s = 31'h2A5C_3F17;
        gen_ref(s, 140);
        seed = s;
        burst_len = 16'd7;
        gap_len = 8'd0;
        num_bursts = 8'd0;
        pulse_start();
        nv = 0;
        seen_done = 0;
        bad_bits = 0;
        for (int t = 0; t < 400 && nv < 100; t++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (bit_valid) begin
                if (bit_out !== ref_bits[nv]) bad_bits++;
                nv++;
            end
        end
        chk("abort reach100", nv, 100);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort busy/valid/en", {busy, bit_valid, gen_en}, 0);
        chk("abort stream", bad_bits, 0);
        chk("abort no done", seen_done + int'(done), 0);
        chk("abort idx", burst_idx, 14);
        repeat (3) @(negedge clk);
        chk("abort idx hold", burst_idx, 14);

        // start and abort together in IDLE: start wins, start clears idx
        seed = 31'h0BAD_F00D;
        burst_len = 16'd2;
        gap_len = 8'd0;
        num_bursts = 8'd1;
        abort = 1'b1;
        pulse_start();
        abort = 1'b0;
        @(negedge clk);
        chk("start+abort load", {busy, gen_load}, 2'b11);
        chk("start clears idx", burst_idx, 0);
        seen_done = 0;
        for (int t = 0; t < 20 && !seen_done; t++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("start+abort done", seen_done, 1);
        @(negedge clk);

        // start during RUN ignored, then mid-burst reset
        s = 31'h1357_9BDF;
        seed = s;
        burst_len = 16'd20;
        gap_len = 8'd0;
        num_bursts = 8'd1;
        pulse_start();
        repeat (3) @(negedge clk);
        seed = 31'h7777_0000;
        burst_len = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("run start ignored", {bit_valid, gen_load, gen_seed}, {2'b10, s});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst outputs",
            {gen_load, gen_en, bit_valid, busy, done, burst_idx}, 0);
        chk("midrst gen_seed", gen_seed, 31'd1);

        // randomized bursts against the trace model
        for (int r = 0; r < 25; r++) begin
            s = ($urandom_range(0, 4) == 0) ? 31'h0 : 31'($urandom);
            run_trace($sformatf("rnd%0d", r), s, $urandom_range(1, 10),
                      $urandom_range(0, 3), $urandom_range(1, 4), -1);
        end

`ifdef PRBS_ERR_INJ_EN
        err_pos = 16'd5;
        err_inj = 1'b1;
        @(negedge clk);
        err_inj = 1'b0;
        run_trace("inj", 31'h3C3C_5A5A, 8, 2, 2, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
